stage_sequencer: RTL and testbench

Initiator-side driver for a 2-head stage block.
- Buffers one frame of tokens from upstream.
- Issues the tokens one at a time to the stage using its en / end-flag protocol.
- Captures each stage result and replays the frame downstream over a valid/ready interface.
- Sits between the token source (or the previous stage's output) and a Stage_2head-style block.

---
 rtl/definition_pkg.sv | 27 ++
 rtl/stage_sequencer_frame_buf.sv | 49 ++++
 rtl/stage_sequencer.sv | 243 ++++++++++++++++++++++++
 tb/tb_stage_sequencer.sv | 322 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/definition_pkg.sv
`default_nettype none
// ============================================================================
// Module      : definition (package)
// Description : Shared width, timeout default and FSM state encoding for the
//               stage sequencer and its frame buffer.
// Revision    : 1.0 - initial release
// ============================================================================
package definition;

    // Token / result width shared with the stage block.
    localparam int att_width   = 16;

    // Default number of cycles st_en may stay high without st_end.
    localparam int SEQ_TIMEOUT = 255;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        LOAD  = 3'd1,
        ISSUE = 3'd2,
        WAIT  = 3'd3,
        GAP   = 3'd4,
        DRAIN = 3'd5,
        ERR   = 3'd6
    } seq_state_t;

endpackage
`default_nettype wire

// File: rtl/stage_sequencer_frame_buf.sv
`default_nettype none
// ============================================================================
// Module      : seq_frame_buf
// Description : Two independent N_TOK-entry register arrays. tok_buf holds
//               the frame received from upstream, res_buf holds the stage
//               results. Each array has one synchronous write port and one
//               combinational read port. Contents are not reset.
// Ports       : clk                         clock
//               tok_we/tok_waddr/tok_wdata  token write port
//               tok_raddr/tok_rdata         token read port
//               res_we/res_waddr/res_wdata  result write port
//               res_raddr/res_rdata         result read port
// Revision    : 1.0 - initial release
// ============================================================================
module seq_frame_buf #(
    parameter int N_TOK = 16,
    parameter int DW    = 16,
    parameter int IW    = $clog2(N_TOK)
) (
    input  logic          clk,
    input  logic          tok_we,
    input  logic [IW-1:0] tok_waddr,
    input  logic [DW-1:0] tok_wdata,
    input  logic [IW-1:0] tok_raddr,
    output logic [DW-1:0] tok_rdata,
    input  logic          res_we,
    input  logic [IW-1:0] res_waddr,
    input  logic [DW-1:0] res_wdata,
    input  logic [IW-1:0] res_raddr,
    output logic [DW-1:0] res_rdata
);

    logic [DW-1:0] r_tok [N_TOK];
    logic [DW-1:0] r_res [N_TOK];

    always_ff @(posedge clk) begin
        if (tok_we) begin
            r_tok[tok_waddr] <= tok_wdata;
        end
        if (res_we) begin
            r_res[res_waddr] <= res_wdata;
        end
    end

    assign tok_rdata = r_tok[tok_raddr];
    assign res_rdata = r_res[res_raddr];

endmodule
`default_nettype wire

// File: rtl/stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : stage_sequencer
// Description : Initiator-side driver for a 2-head stage block. Buffers one
//               frame of N_TOK tokens, issues them one at a time over the
//               st_en / st_end protocol, captures each result and replays the
//               frame downstream over valid/ready.
// Ports       : clk, rstn (async active-low), clr (sync clear)
//               in_valid/in_ready/in_data        upstream token interface
//               bias_1/bias_2                    biases, latched on 1st token
//               st_en/st_data/st_bias_1/2        stage request
//               st_end/st_result                 stage completion
//               out_valid/out_ready/out_data     downstream result interface
//               busy, done (1-cycle pulse), err (sticky timeout)
// Revision    : 1.0 - initial release
// ============================================================================
module stage_sequencer
    import definition::*;
#(
    parameter int N_TOK   = 16,
    parameter int TIMEOUT = SEQ_TIMEOUT,
    parameter int DW      = att_width
) (
    input  logic          clk,
    input  logic          rstn,
    input  logic          clr,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] in_data,
    input  logic [DW-1:0] bias_1,
    input  logic [DW-1:0] bias_2,
    output logic          st_en,
    output logic [DW-1:0] st_data,
    output logic [DW-1:0] st_bias_1,
    output logic [DW-1:0] st_bias_2,
    input  logic          st_end,
    input  logic [DW-1:0] st_result,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [DW-1:0] out_data,
    output logic          busy,
    output logic          done,
    output logic          err
);

    localparam int IW = $clog2(N_TOK);
    localparam int CW = $clog2(TIMEOUT + 1);

    localparam logic [IW-1:0] c_last_idx = IW'(N_TOK - 1);
    // The counter holds the number of WAIT cycles already spent without
    // st_end. Erroring when it would step to TIMEOUT bounds st_en high time
    // to exactly TIMEOUT cycles; st_end in that final cycle still wins.
    localparam logic [CW-1:0] c_cnt_lim  = CW'(TIMEOUT - 1);

    seq_state_t    r_state;
    seq_state_t    w_state_nxt;

    logic [IW-1:0] r_idx;
    logic [CW-1:0] r_cnt;
    logic          r_err;
    logic          r_st_en;
    logic [DW-1:0] r_st_data;
    logic [DW-1:0] r_bias_1;
    logic [DW-1:0] r_bias_2;

    logic          w_last;
    logic          w_tok_we;
    logic [IW-1:0] w_tok_waddr;
    logic [DW-1:0] w_tok_rdata;
    logic          w_res_we;
    logic [DW-1:0] w_res_rdata;

    assign w_last = (r_idx == c_last_idx);

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next state and handshake outputs
    // ------------------------------------------------------------------
    always_comb begin
        w_state_nxt = r_state;
        in_ready    = 1'b0;
        out_valid   = 1'b0;
        done        = 1'b0;

        case (r_state)
            IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_nxt = LOAD;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                if (in_valid && w_last) begin
                    w_state_nxt = ISSUE;
                end
            end
            ISSUE: begin
                w_state_nxt = WAIT;
            end
            WAIT: begin
                if (st_end) begin
                    w_state_nxt = GAP;
                end else if (r_cnt == c_cnt_lim) begin
                    w_state_nxt = ERR;
                end
            end
            GAP: begin
                w_state_nxt = w_last ? DRAIN : ISSUE;
            end
            DRAIN: begin
                out_valid = 1'b1;
                if (out_ready && w_last) begin
                    done        = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            ERR: begin
                w_state_nxt = ERR;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase

        // Clear overrides everything; nothing handshakes in that cycle.
        if (clr) begin
            w_state_nxt = IDLE;
            in_ready    = 1'b0;
            out_valid   = 1'b0;
            done        = 1'b0;
        end
    end

    // ------------------------------------------------------------------
    // Datapath: index, timeout counter, stage request registers, error
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_idx     <= '0;
            r_cnt     <= '0;
            r_err     <= 1'b0;
            r_st_en   <= 1'b0;
            r_st_data <= '0;
            r_bias_1  <= '0;
            r_bias_2  <= '0;
        end else if (clr) begin
            r_idx   <= '0;
            r_cnt   <= '0;
            r_err   <= 1'b0;
            r_st_en <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (in_valid) begin
                        r_bias_1 <= bias_1;
                        r_bias_2 <= bias_2;
                        r_idx    <= IW'(1);
                    end
                end
                LOAD: begin
                    if (in_valid) begin
                        r_idx <= w_last ? '0 : r_idx + IW'(1);
                    end
                end
                ISSUE: begin
                    r_st_data <= w_tok_rdata;
                    r_st_en   <= 1'b1;
                    r_cnt     <= '0;
                end
                WAIT: begin
                    if (st_end) begin
                        r_st_en <= 1'b0;
                    end else begin
                        r_cnt <= r_cnt + CW'(1);
                        if (r_cnt == c_cnt_lim) begin
                            r_err   <= 1'b1;
                            r_st_en <= 1'b0;
                        end
                    end
                end
                GAP: begin
                    r_idx <= w_last ? '0 : r_idx + IW'(1);
                end
                DRAIN: begin
                    if (out_ready) begin
                        r_idx <= w_last ? '0 : r_idx + IW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Frame storage
    // ------------------------------------------------------------------
    assign w_tok_we    = in_valid && in_ready;
    assign w_tok_waddr = (r_state == IDLE) ? '0 : r_idx;
    assign w_res_we    = (r_state == WAIT) && st_end && !clr;

    seq_frame_buf #(
        .N_TOK (N_TOK),
        .DW    (DW),
        .IW    (IW)
    ) u_frame_buf (
        .clk       (clk),
        .tok_we    (w_tok_we),
        .tok_waddr (w_tok_waddr),
        .tok_wdata (in_data),
        .tok_raddr (r_idx),
        .tok_rdata (w_tok_rdata),
        .res_we    (w_res_we),
        .res_waddr (r_idx),
        .res_wdata (st_result),
        .res_raddr (r_idx),
        .res_rdata (w_res_rdata)
    );

    // ------------------------------------------------------------------
    // Outputs
    // ------------------------------------------------------------------
    assign st_en     = r_st_en;
    assign st_data   = r_st_data;
    assign st_bias_1 = r_bias_1;
    assign st_bias_2 = r_bias_2;
    assign out_data  = out_valid ? w_res_rdata : '0;
    assign busy      = (r_state != IDLE);
    assign err       = r_err;

endmodule
`default_nettype wire

// File: tb/tb_stage_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_stage_sequencer
// Description : Self-checking bench for stage_sequencer. A behavioural stage
//               answers st_en after a programmable delay with token*2; a
//               scoreboard of expected results is filled when tokens are
//               driven and drained when the sequencer emits results.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_stage_sequencer;
    import definition::*;

    localparam int N  = 16;
    localparam int TO = SEQ_TIMEOUT;
    localparam int DW = att_width;

    logic          clk       = 1'b0;
    logic          rstn      = 1'b0;
    logic          clr       = 1'b0;
    logic          in_valid  = 1'b0;
    logic [DW-1:0] in_data   = '0;
    logic [DW-1:0] bias_1    = '0;
    logic [DW-1:0] bias_2    = '0;
    logic          st_end    = 1'b0;
    logic [DW-1:0] st_result = '0;
    logic          out_ready = 1'b0;
    logic          in_ready;
    logic          st_en;
    logic [DW-1:0] st_data;
    logic [DW-1:0] st_bias_1;
    logic [DW-1:0] st_bias_2;
    logic          out_valid;
    logic [DW-1:0] out_data;
    logic          busy;
    logic          done;
    logic          err;

    stage_sequencer dut (
        .clk       (clk),
        .rstn      (rstn),
        .clr       (clr),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .bias_1    (bias_1),
        .bias_2    (bias_2),
        .st_en     (st_en),
        .st_data   (st_data),
        .st_bias_1 (st_bias_1),
        .st_bias_2 (st_bias_2),
        .st_end    (st_end),
        .st_result (st_result),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .busy      (busy),
        .done      (done),
        .err       (err)
    );

    always #5 clk = ~clk;

    int   n_checks    = 0;
    int   n_fail      = 0;
    int   exp_q[$];
    int   tok_q[$];
    int   stage_delay = 2;
    bit   glitch      = 1'b0;
    bit   rdy_mode    = 1'b0;
    int   exp_b1      = 0;
    int   exp_b2      = 0;
    int   done_cnt    = 0;
    int   frame_pos   = 0;
    int   wcnt        = 0;
    int   cyc         = 0;
    bit   hold_pend   = 1'b0;
    bit   done_prev   = 1'b0;
    logic [DW-1:0] hold_val = '0;
    logic [3:0]    rdy_pat  = 4'b1001;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behavioural stage: st_end in the stage_delay-th cycle of st_en high.
    initial begin
        forever begin
            @(negedge clk);
            if (st_en === 1'b1) begin
                wcnt++;
                if (stage_delay != 0 && wcnt == stage_delay) begin
                    if (tok_q.size() == 0) begin
                        check("stage_tok_queue", tok_q.size(), 1);
                    end else begin
                        check("st_data", st_data, tok_q.pop_front());
                    end
                    check("st_bias_1", st_bias_1, exp_b1);
                    check("st_bias_2", st_bias_2, exp_b2);
                    st_end    = 1'b1;
                    st_result = {st_data[DW-2:0], 1'b0};
                end else begin
                    st_end    = 1'b0;
                    st_result = 16'hBEEF;
                end
            end else begin
                wcnt      = 0;
                st_end    = glitch;
                st_result = glitch ? 16'hDEAD : '0;
            end
        end
    end

    // Downstream sink and result monitor.
    initial begin
        forever begin
            @(negedge clk);
            out_ready = rdy_mode ? rdy_pat[cyc % 4] : 1'b1;
            cyc++;
            #2;
            if (done_prev) begin
                check("busy_after_done", busy, 0);
                done_prev = 1'b0;
            end
            if (hold_pend) begin
                check("hold_valid", out_valid, 1);
                check("hold_data", out_data, hold_val);
                hold_pend = 1'b0;
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check("result_queue", exp_q.size(), 1);
                end else begin
                    check("out_data", out_data, exp_q.pop_front());
                end
                frame_pos++;
                check("done_at_last", done, frame_pos == N);
                if (frame_pos == N) begin
                    check("busy_at_done", busy, 1);
                    done_prev = 1'b1;
                    frame_pos = 0;
                end
            end else if (done) begin
                check("done_spurious", done, 0);
            end
            if (done) done_cnt++;
            if (out_valid && !out_ready) begin
                hold_pend = 1'b1;
                hold_val  = out_data;
            end
        end
    end

    task automatic check_zero();
        check("zero_st_en", st_en, 0);
        check("zero_st_data", st_data, 0);
        check("zero_st_bias_1", st_bias_1, 0);
        check("zero_st_bias_2", st_bias_2, 0);
        check("zero_out_valid", out_valid, 0);
        check("zero_out_data", out_data, 0);
        check("zero_busy", busy, 0);
        check("zero_done", done, 0);
        check("zero_err", err, 0);
    endtask

    // Biases are valid only with the first token; later cycles carry junk
    // so that per-frame latching is exercised.
    task automatic send_frame(input int base, input int b1, input int b2);
        exp_b1 = b1;
        exp_b2 = b2;
        for (int i = 0; i < N; i++) begin
            @(negedge clk);
            in_valid = 1'b1;
            in_data  = DW'(base + i);
            bias_1   = (i == 0) ? DW'(b1) : DW'(b1 + 3 + i);
            bias_2   = (i == 0) ? DW'(b2) : DW'(b2 + 9 + i);
            tok_q.push_back((base + i) & 16'hFFFF);
            exp_q.push_back(((base + i) * 2) & 16'hFFFF);
            #3;
            check("in_ready_load", in_ready, 1);
        end
        @(negedge clk);
        in_valid = 1'b0;
        in_data  = '0;
    endtask

    task automatic wait_drained(input int budget);
        int n = 0;
        while ((busy !== 1'b0 || exp_q.size() != 0) && n < budget) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("frame_within_budget", n < budget, 1);
    endtask

    task automatic run_frame(input int base, input int b1, input int b2, input int budget);
        int d0 = done_cnt;
        send_frame(base, b1, b2);
        wait_drained(budget);
        check("done_once", done_cnt - d0, 1);
        check("idle_after_frame", busy, 0);
        check("no_err_after_frame", err, 0);
    endtask

    initial begin
        int n;
        // Reset state.
        rstn = 1'b0;
        repeat (2) @(negedge clk);
        #3;
        check_zero();
        @(negedge clk);
        rstn = 1'b1;
        #3;
        check("idle_in_ready", in_ready, 1);

        // Nominal frame, tokens 1..16, result token*2.
        run_frame(1, 5, 7, 2000);

        // Downstream back-pressure 1,0,0,1.
        rdy_mode = 1'b1;
        run_frame(200, 3, 4, 2000);
        rdy_mode = 1'b0;

        // st_end asserted outside WAIT must not be captured.
        glitch      = 1'b1;
        stage_delay = 3;
        run_frame(60, 21, 22, 2000);
        glitch      = 1'b0;
        stage_delay = 2;

        // Stage never answers: timeout error.
        stage_delay = 0;
        send_frame(40, 1, 2);
        n = 0;
        while (st_en !== 1'b1 && n < 100) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("st_en_rise", st_en, 1);
        n = 0;
        while (err !== 1'b1 && n < 400) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("timeout_cycles", n, TO);
        check("err_st_en", st_en, 0);
        check("err_in_ready", in_ready, 0);
        check("err_out_valid", out_valid, 0);
        check("err_busy", busy, 1);
        repeat (3) @(negedge clk);
        #3;
        check("err_sticky", err, 1);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        in_data  = 16'd77;
        #3;
        check("clr_in_ready", in_ready, 0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        #3;
        check("clr_err", err, 0);
        check("clr_busy", busy, 0);
        @(negedge clk);
        clr      = 1'b1;
        in_valid = 1'b1;
        #3;
        check("clr_idle_in_ready", in_ready, 0);
        @(negedge clk);
        clr      = 1'b0;
        in_valid = 1'b0;
        #3;
        check("clr_token_dropped", busy, 0);
        tok_q.delete();
        exp_q.delete();
        stage_delay = 2;

        // Reset mid-WAIT at token 9, then a clean frame.
        send_frame(1, 5, 7);
        n = 0;
        while (!(st_en === 1'b1 && st_data == 16'd9) && n < 300) begin
            @(negedge clk);
            #3;
            n++;
        end
        check("reached_token9", st_data, 9);
        rstn = 1'b0;
        #1;
        check_zero();
        @(negedge clk);
        rstn = 1'b1;
        tok_q.delete();
        exp_q.delete();
        frame_pos = 0;
        run_frame(100, 8, 9, 2000);

        // Completion in the last cycle before timeout.
        stage_delay = TO;
        run_frame(300, 11, 13, 6000);
        stage_delay = 2;

        repeat (3) @(negedge clk);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
